// File: rtl/w_trace_uart_tx.sv
// w_trace_uart_tx: watches the CPU W register and sends every new value
// out as an 8N1 UART frame. Captures are buffered in a small FIFO; the CPU
// is never stalled, so a full FIFO drops the byte and raises a sticky flag.
module w_trace_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    w_value,
   input  logic                          capture_en,
   input  logic                          clr_overflow,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic [7:0]    r_last;
   logic          r_ovf;
   logic [1:0]    r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;

   logic w_push;
   logic w_pop;
   logic w_push_ok;
   logic w_empty;
   logic w_baud_end;

   assign w_push     = (w_value != r_last) && capture_en;
   assign w_empty    = (r_count == '0);
   assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));
   // Pop either when idle or at the last stop-bit cycle, giving gapless frames
   assign w_pop      = !w_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));
   // A pop on the same edge frees a slot, so a full FIFO can still accept
   assign w_push_ok  = w_push && ((r_count != (AW+1)'(FIFO_DEPTH)) || w_pop);

   // Track the last seen W value; reset value matches the CPU's W reset value
   always_ff @(posedge clk) begin
      if (reset) r_last <= 8'h00;
      else       r_last <= w_value;
   end

   // FIFO storage write; contents need no reset since pointers gate validity
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= w_value;
   end

   // FIFO pointers, occupancy and sticky overflow flag (set beats clear)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + AW'(1);
         if (w_pop)     r_rptr <= r_rptr + AW'(1);
         if (w_push_ok && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (!w_push_ok && w_pop) r_count <= r_count - (AW+1)'(1);
         if (w_push && !w_push_ok) r_ovf <= 1'b1;
         else if (clr_overflow)    r_ovf <= 1'b0;
      end
   end

   // Transmit FSM: start bit, 8 data bits LSB first, stop bit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_shift <= r_mem[r_rptr];
                  r_baud  <= '0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            S_DATA: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_shift <= {1'b0, r_shift[7:1]};
                  if (r_bit == 3'd7) r_state <= S_STOP;
                  else               r_bit   <= r_bit + 3'd1;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            S_STOP: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (!w_empty) begin
                     r_shift <= r_mem[r_rptr];
                     r_state <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign tx         = (r_state == S_START) ? 1'b0 :
                       (r_state == S_DATA)  ? r_shift[0] : 1'b1;
   assign busy       = (r_state != S_IDLE);
   assign fifo_count = r_count;
   assign overflow   = r_ovf;

endmodule

// File: tb/tb_w_trace_uart_tx.sv
// Directed bench for w_trace_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_w_trace_uart_tx;

   localparam int CPB = 4;
   localparam int DEP = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] w_value;
   logic       capture_en;
   logic       clr_overflow;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;
   logic       overflow;

   int n_cmp  = 0;
   int n_fail = 0;

   w_trace_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
      .clk(clk), .reset(reset), .w_value(w_value), .capture_en(capture_en),
      .clr_overflow(clr_overflow), .tx(tx), .busy(busy),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Checks idle outputs every cycle for n cycles
   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         chk(tag, {28'd0, tx, busy, overflow, 1'b0} | {29'd0, fifo_count}, 32'h8);
         step();
      end
   endtask

   // Checks tx/busy for frame cycles first..39 of byte b; entry point is just
   // after the edge that begins frame cycle 'first'
   task automatic frame(input logic [7:0] b, input int first);
      for (int i = first; i < 10*CPB; i++) begin
         int   bi;
         logic e;
         bi = i / CPB;
         if (bi == 0)      e = 1'b0;
         else if (bi == 9) e = 1'b1;
         else              e = b[bi-1];
         chk($sformatf("frame_%02h_c%0d", b, i), {31'd0, tx}, {31'd0, e});
         chk("frame_busy", {31'd0, busy}, 32'd1);
         step();
      end
   endtask

   initial begin
      reset = 1'b1; w_value = 8'h00; capture_en = 1'b1; clr_overflow = 1'b0;
      step();
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cnt", {29'd0, fifo_count}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      step();
      reset = 1'b0;

      // No change from reset value: nothing sent
      idle("hold00", 200);

      // Single A5 frame, 1-cycle latency, busy falls at k+41
      w_value = 8'hA5;
      step();
      chk("a5_cnt", {29'd0, fifo_count}, 32'd1);
      chk("a5_tx_k", {31'd0, tx}, 32'd1);
      step();
      frame(8'hA5, 0);
      chk("a5_busy_end", {31'd0, busy}, 32'd0);
      chk("a5_cnt_end", {29'd0, fifo_count}, 32'd0);
      step();

      // Burst 01..05 fills FIFO to 4, 06 dropped
      w_value = 8'h01; step();
      w_value = 8'h02; step();
      chk("burst_cnt1", {29'd0, fifo_count}, 32'd1);
      w_value = 8'h03; step();
      w_value = 8'h04; step();
      w_value = 8'h05; step();
      chk("burst_peak", {29'd0, fifo_count}, 32'd4);
      chk("burst_ovf0", {31'd0, overflow}, 32'd0);
      w_value = 8'h06; step();
      chk("drop_ovf", {31'd0, overflow}, 32'd1);
      chk("drop_cnt", {29'd0, fifo_count}, 32'd4);
      frame(8'h01, 4);
      frame(8'h02, 0);
      frame(8'h03, 0);
      frame(8'h04, 0);
      frame(8'h05, 0);
      chk("burst_busy_end", {31'd0, busy}, 32'd0);
      chk("burst_cnt_end", {29'd0, fifo_count}, 32'd0);
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);
      clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
      chk("ovf_clr", {31'd0, overflow}, 32'd0);

      // Refill, then a drop on the same edge as clr_overflow: set wins
      w_value = 8'h07; step();
      w_value = 8'h08; step();
      w_value = 8'h09; step();
      w_value = 8'h0A; step();
      w_value = 8'h0B; step();
      chk("refill_cnt", {29'd0, fifo_count}, 32'd4);
      w_value = 8'h0C; clr_overflow = 1'b1; step();
      chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
      step(); clr_overflow = 1'b0;
      chk("ovf_clr2", {31'd0, overflow}, 32'd0);
      frame(8'h07, 5);
      frame(8'h08, 0);
      frame(8'h09, 0);
      frame(8'h0A, 0);
      frame(8'h0B, 0);
      chk("refill_busy_end", {31'd0, busy}, 32'd0);

      // One change, held: exactly one frame
      w_value = 8'h33; step(); step();
      frame(8'h33, 0);
      idle("hold33", 100);

      // capture_en low: change tracked but not sent
      capture_en = 1'b0; w_value = 8'h44; step();
      chk("cap_off_cnt", {29'd0, fifo_count}, 32'd0);
      idle("cap_off", 60);
      capture_en = 1'b1; w_value = 8'h55; step();
      chk("cap_on_cnt", {29'd0, fifo_count}, 32'd1);
      step();
      frame(8'h55, 0);
      idle("after55", 50);

      // Reset during DATA bit 3 with two bytes queued
      w_value = 8'h10; step();
      w_value = 8'h20; step();
      w_value = 8'h30; step();
      for (int i = 0; i < 16; i++) step();
      chk("mid_cnt", {29'd0, fifo_count}, 32'd2);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      chk("mid_bit3", {31'd0, tx}, 32'd0);
      reset = 1'b1; w_value = 8'h00; step();
      chk("abort_tx", {31'd0, tx}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_cnt", {29'd0, fifo_count}, 32'd0);
      reset = 1'b0;
      idle("post_abort", 60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
